// File: rtl/uart_rx_framer.sv
// Purpose: synchronise the rx pin, detect start bits, majority-vote each bit at mid-period and assemble 8-bit frames with optional parity.
// Latency: result pulses appear 1 clk after the stop-bit decision point; the start edge is seen SYNC_STAGES+1 clk after the wire edge.
// Backpressure: none; the downstream FIFO must accept every dataAvailable pulse.
module uart_rx_framer #(
   parameter int CLOCK_SCALE_BITS = 16,
   parameter int SYNC_STAGES      = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
   input  logic [1:0]                  parityMode,
   input  logic                        rx,
   output logic [7:0]                  dataOut,
   output logic                        dataAvailable,
   output logic                        parityError,
   output logic                        framingError,
   output logic                        breakDetect,
   output logic                        busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rxStateT;

   localparam logic [CLOCK_SCALE_BITS-1:0] ONE = CLOCK_SCALE_BITS'(1);

   rxStateT                     rxState, rxStateNext;
   logic [SYNC_STAGES-1:0]      syncQ;
   logic                        rxs;
   logic                        rxsPrev;
   logic [CLOCK_SCALE_BITS-1:0] cnt, cntNext;
   logic [2:0]                  bitIdx, bitIdxNext;
   logic [7:0]                  shiftReg, shiftNext;
   logic                        samp0, samp0Next;
   logic                        samp1, samp1Next;
   logic                        parFlag, parFlagNext;
   logic [7:0]                  dataOutNext;
   logic                        dataAvailNext, parityErrNext, framingNext, breakNext;

   logic [CLOCK_SCALE_BITS-1:0] half, halfM1, halfP1;
   logic                        wrap, decide, majority, startFall, parityOn, oddMode;

   assign rxs       = syncQ[SYNC_STAGES-1];
   assign startFall = rxsPrev & ~rxs;
   assign half      = cyclesPerBit >> 1;
   assign halfM1    = half - ONE;
   assign halfP1    = half + ONE;
   // >= rather than == so a cyclesPerBit change mid-frame can never let the counter run away
   assign wrap      = (cnt >= cyclesPerBit);
   assign decide    = (cnt == halfP1);
   // Third sample is the live synchronised value at the decision cycle
   assign majority  = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
   assign parityOn  = (parityMode == 2'b01) || (parityMode == 2'b10);
   assign oddMode   = (parityMode == 2'b10);
   assign busy      = (rxState != IDLE);

   // Input synchroniser plus one-cycle history for start-edge detection; resets to the idle (high) level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         syncQ   <= '1;
         rxsPrev <= 1'b1;
      end else begin
         syncQ   <= {syncQ[SYNC_STAGES-2:0], rx};
         rxsPrev <= rxs;
      end
   end

   // Next-state, bit-timing and frame-assembly decisions
   always_comb begin
      rxStateNext   = rxState;
      cntNext       = cnt;
      bitIdxNext    = bitIdx;
      shiftNext     = shiftReg;
      samp0Next     = samp0;
      samp1Next     = samp1;
      parFlagNext   = parFlag;
      dataOutNext   = dataOut;
      dataAvailNext = 1'b0;
      parityErrNext = 1'b0;
      framingNext   = 1'b0;
      breakNext     = 1'b0;

      if (cnt == halfM1) samp0Next = rxs;
      if (cnt == half)   samp1Next = rxs;

      case (rxState)
         IDLE: begin
            cntNext    = '0;
            bitIdxNext = '0;
            if (startFall) rxStateNext = START;
         end
         START: begin
            cntNext = wrap ? '0 : cnt + ONE;
            if (decide && majority) begin
               // Start bit did not survive the vote: treat it as line noise
               rxStateNext = IDLE;
               cntNext     = '0;
            end else if (wrap) begin
               rxStateNext = DATA;
               bitIdxNext  = '0;
               parFlagNext = 1'b0;
            end
         end
         DATA: begin
            cntNext = wrap ? '0 : cnt + ONE;
            // Shift in at the MSB so the first wire bit lands at bit 0 after eight bits
            if (decide) shiftNext = {majority, shiftReg[7:1]};
            if (wrap) begin
               bitIdxNext = bitIdx + 3'd1;
               if (bitIdx == 3'd7) rxStateNext = parityOn ? PARITY : STOP;
            end
         end
         PARITY: begin
            cntNext = wrap ? '0 : cnt + ONE;
            if (decide) parFlagNext = (^shiftReg) ^ majority ^ oddMode;
            if (wrap) rxStateNext = STOP;
         end
         STOP: begin
            cntNext = wrap ? '0 : cnt + ONE;
            // Act at the decision point, not at wrap, so a back-to-back start edge is not missed
            if (decide) begin
               cntNext = '0;
               if (majority) begin
                  dataOutNext   = shiftReg;
                  dataAvailNext = 1'b1;
                  parityErrNext = parFlag;
                  rxStateNext   = IDLE;
               end else if (|shiftReg) begin
                  framingNext = 1'b1;
                  rxStateNext = WAIT_IDLE;
               end else begin
                  breakNext   = 1'b1;
                  rxStateNext = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            cntNext = '0;
            if (rxs) rxStateNext = IDLE;
         end
         default: begin
            rxStateNext = IDLE;
            cntNext     = '0;
         end
      endcase
   end

   // State and datapath registers; registering the pulses gives the one-cycle decision-to-output latency
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxState       <= IDLE;
         cnt           <= '0;
         bitIdx        <= '0;
         shiftReg      <= '0;
         samp0         <= 1'b1;
         samp1         <= 1'b1;
         parFlag       <= 1'b0;
         dataOut       <= '0;
         dataAvailable <= 1'b0;
         parityError   <= 1'b0;
         framingError  <= 1'b0;
         breakDetect   <= 1'b0;
      end else begin
         rxState       <= rxStateNext;
         cnt           <= cntNext;
         bitIdx        <= bitIdxNext;
         shiftReg      <= shiftNext;
         samp0         <= samp0Next;
         samp1         <= samp1Next;
         parFlag       <= parFlagNext;
         dataOut       <= dataOutNext;
         dataAvailable <= dataAvailNext;
         parityError   <= parityErrNext;
         framingError  <= framingNext;
         breakDetect   <= breakNext;
      end
   end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Receive-side front end of the UART peripheral: synchronises the raw rx pin, detects start bits, majority-samples each bit at mid-period and assembles 8-bit frames with optional parity.
- Sits directly upstream of the rx FIFO. The parent drives FIFO `we` from `dataAvailable`, and exposes the error/break flags through the status register path.

Parameters:
- CLOCK_SCALE_BITS, 16, width of the `cyclesPerBit` input and of the internal bit-period counter.
- SYNC_STAGES, 2, number of flops in the rx input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- cyclesPerBit  input  CLOCK_SCALE_BITS  bit period minus one, in clk cycles; minimum legal value 4
- parityMode  input  2  00 = none, 01 = even, 10 = odd, 11 = none
- rx  input  1  serial input, idle high (parent forces 1 when disabled)
- dataOut  output  8  last received byte, LSB first on the wire
- dataAvailable  output  1  one-cycle pulse: dataOut valid
- parityError  output  1  one-cycle pulse, coincident with dataAvailable
- framingError  output  1  one-cycle pulse: stop bit sampled low
- breakDetect  output  1  one-cycle pulse: break condition detected
- busy  output  1  high in any state other than IDLE

Behaviour:

Reset:
- All outputs are 0 on reset. State is IDLE, counter is 0, bit index is 0.
- Synchroniser flops reset to 1 (idle line).
- Reset asserted mid-frame aborts the frame immediately; no pulse is emitted.

Synchroniser and start detect:
- rx passes through SYNC_STAGES flops; rxs is the synchronised value.
- Start is detected when rxs falls (one-cycle history register).

Timing:
- Bit period is cyclesPerBit+1 cycles.
- half = cyclesPerBit>>1.
- The counter runs 0..cyclesPerBit and wraps to 0, advancing the bit.
- Three samples are taken at counter = half-1, half and half+1. Bit value is the majority of the three, decided at half+1.

States:
- IDLE: on the rxs falling edge, go to START with counter = 0.
- START: at decision, majority 1 means a glitch: return to IDLE with no pulse. Majority 0 means continue; at wrap go to DATA with bit index 0.
- DATA: shift the majority value into the shift register MSB-first-in (so the first wire bit ends at bit 0). At wrap after bit 7, go to PARITY if parityMode is 01/10, else STOP.
- PARITY: parity error when
  - even mode: XOR of the 8 data bits and the parity bit is 1;
  - odd mode: that XOR is 0.
  At wrap go to STOP.
- STOP: act at the decision point (half+1). Do not wait for wrap, so back-to-back frames are not missed.
  - Majority 1: dataOut is loaded, dataAvailable pulses next cycle (with parityError if flagged), go to IDLE.
  - Majority 0 and any data bit 1: framingError pulses, the byte is discarded (no dataAvailable), go to WAIT_IDLE.
  - Majority 0 and data all zero: breakDetect pulses, no dataAvailable, go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs = 1, then go to IDLE. A new start is only recognised after rx has returned high.

Latency and other rules:
- Latency from the stop-bit mid-point to dataAvailable is 1 cycle.
- dataOut holds its value until the next good frame.
- cyclesPerBit is sampled continuously. Changing it mid-frame has undefined frame result but must not hang the FSM; the counter wrap compare uses >= so it cannot overrun.
- Pulses are never asserted simultaneously except dataAvailable with parityError.

Test Plan:
- cyclesPerBit=15, parity none, send 0xA5 -> dataOut=0xA5, one dataAvailable pulse ~1 cycle after stop mid-point, no error pulses, busy returns low.
- cyclesPerBit=15, even parity, send 0x07 with parity bit 0 (wrong) -> dataAvailable and parityError both pulse; dataOut=0x07. Resend with parity 1 -> no parityError.
- Stop bit held low, data 0x41 -> framingError pulse, no dataAvailable, FSM waits in WAIT_IDLE until rx goes high, then receives next frame 0x42 correctly.
- rx low for 12 bit periods -> single breakDetect pulse, no dataAvailable/framingError, no new frame until rx high.
- 3-cycle low glitch on idle line (cyclesPerBit=15) -> returns to IDLE, no pulses. Single-cycle glitch at mid-bit of data bit 3 -> majority vote rejects it, byte correct.
- Back-to-back frames 0x55, 0xAA with no idle gap; assert rst mid-second-frame -> first byte delivered, outputs 0 immediately on reset, no pulse for the aborted frame, next frame after reset received.
